// File: rtl/alu_sequencer.sv
// Sequences 32-bit requests onto an external 16-bit combinational ALU.
// ADD32 takes three passes: low half, high half, then folding the low carry into the high sum.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_out,
    input  logic        carry_out,
    input  logic        overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_carry,
    output logic        rsp_ovf,
    output logic        rsp_err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PASS_LO  = 3'd1,
        PASS_HI  = 3'd2,
        PASS_FIX = 3'd3,
        RESP     = 3'd4
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;

    state_t      state_reg, state_next;
    logic [3:0]  op_reg;
    logic [31:0] a_reg, b_reg;
    logic        c0_reg, c1_reg;
    logic [15:0] h_reg;
    logic [31:0] rsp_data_reg;
    logic        rsp_carry_reg, rsp_ovf_reg, rsp_err_reg;
    logic        is_add32;

    assign is_add32  = (op_reg == 4'd7);
    assign rsp_data  = rsp_data_reg;
    assign rsp_carry = rsp_carry_reg;
    assign rsp_ovf   = rsp_ovf_reg;
    assign rsp_err   = rsp_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        alu_a      = 16'h0000;
        alu_b      = 16'h0000;
        alu_op     = 3'b000;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_op[3] ? RESP : PASS_LO;
                end
            end
            PASS_LO: begin
                alu_a      = a_reg[15:0];
                alu_b      = b_reg[15:0];
                // ADD32 is the only legal op whose low bits are 111
                alu_op     = is_add32 ? ALU_ADD : op_reg[2:0];
                state_next = is_add32 ? PASS_HI : RESP;
            end
            PASS_HI: begin
                alu_a      = a_reg[31:16];
                alu_b      = b_reg[31:16];
                alu_op     = ALU_ADD;
                state_next = PASS_FIX;
            end
            PASS_FIX: begin
                alu_a      = h_reg;
                alu_b      = {15'b0, c0_reg};
                alu_op     = ALU_ADD;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg        <= 4'h0;
            a_reg         <= 32'h0;
            b_reg         <= 32'h0;
            c0_reg        <= 1'b0;
            c1_reg        <= 1'b0;
            h_reg         <= 16'h0;
            rsp_data_reg  <= 32'h0;
            rsp_carry_reg <= 1'b0;
            rsp_ovf_reg   <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        op_reg        <= req_op;
                        a_reg         <= req_a;
                        b_reg         <= req_b;
                        rsp_data_reg  <= 32'h0;
                        rsp_carry_reg <= 1'b0;
                        rsp_ovf_reg   <= 1'b0;
                        rsp_err_reg   <= req_op[3];
                    end
                end
                PASS_LO: begin
                    if (is_add32) begin
                        rsp_data_reg[15:0] <= alu_out;
                        c0_reg             <= carry_out;
                    end else begin
                        rsp_data_reg  <= {16'h0000, alu_out};
                        rsp_carry_reg <= (op_reg == 4'd2) & carry_out;
                        rsp_ovf_reg   <= ((op_reg == 4'd2) || (op_reg == 4'd3)) & overflow;
                    end
                end
                PASS_HI: begin
                    h_reg  <= alu_out;
                    c1_reg <= carry_out;
                end
                PASS_FIX: begin
                    // carry can come from either the high-half add or the low-carry fold, never both
                    rsp_data_reg[31:16] <= alu_out;
                    rsp_carry_reg       <= c1_reg | carry_out;
                    rsp_ovf_reg         <= (a_reg[31] == b_reg[31]) && (alu_out[15] != a_reg[31]);
                end
                default: ;
            endcase
        end
    end

endmodule
